// File: rtl/wb_resp_mem.sv
// Wishbone B3 memory responder with programmable first-beat wait,
// incrementing-burst support, out-of-range error and ack/err beat counters.
//
// Ports:
//   wb_clk, wb_resetn             clock, async active-low reset
//   wb_cyc, wb_stb, wb_we         bus cycle / strobe / write enable
//   wb_addr[APP_AW]               byte address (bits [1:0] ignored)
//   wb_sel[dw/8], wb_dati[dw]     byte lanes, write data
//   wb_cti[3]                     000 classic, 010 incr burst, 111 end
//   wb_ack, wb_err                registered termination
//   wb_dato[dw]                   read data, zero unless a read is acked
//   ack_cnt, err_cnt              saturating beat counters
module wb_resp_mem #(
    parameter int APP_AW   = 26,
    parameter int dw       = 32,
    parameter int MEM_AW   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              wb_clk,
    input  logic              wb_resetn,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [APP_AW-1:0] wb_addr,
    input  logic [dw/8-1:0]   wb_sel,
    input  logic [dw-1:0]     wb_dati,
    input  logic [2:0]        wb_cti,
    output logic              wb_ack,
    output logic              wb_err,
    output logic [dw-1:0]     wb_dato,
    output logic [15:0]       ack_cnt,
    output logic [15:0]       err_cnt
);

    localparam int         NB    = dw / 8;
    localparam int         DEPTH = 1 << MEM_AW;
    localparam logic [2:0] WC    = 3'(WAIT_CYC);
    localparam logic [2:0] CTI_INC = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [2:0]        wcnt;
    logic              burst_q;
    logic [dw-1:0]     mem [DEPTH];

    logic              req;
    logic              oor;
    logic [MEM_AW-1:0] idx;
    logic              serve;
    logic              mem_we;
    logic              cont;
    logic              unused_addr_lsb;

    assign req  = wb_cyc & wb_stb;
    assign oor  = |wb_addr[APP_AW-1:MEM_AW+2];
    assign idx  = wb_addr[MEM_AW+1:2];
    assign cont = (wb_cti == CTI_INC);

    assign unused_addr_lsb = ^wb_addr[1:0];

    // serve: this edge terminates a beat (ack or err next cycle).
    // In RESP a new beat is only served when the previous beat
    // was tagged as an incrementing burst.
    always_comb begin
        serve = 1'b0;
        unique case (state)
            S_IDLE:  serve = req && (WC == 3'd0);
            S_WAIT:  serve = wb_cyc && (wcnt <= 3'd1);
            S_RESP:  serve = burst_q && req;
            default: serve = 1'b0;
        endcase
    end

    // Reset gating keeps a write from slipping through while
    // reset is held with a live request on the bus.
    assign mem_we = serve & wb_we & ~oor & wb_resetn;

    always_ff @(posedge wb_clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (wb_sel[i]) begin
                    mem[idx][i*8 +: 8] <= wb_dati[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state   <= S_IDLE;
            wcnt    <= 3'd0;
            burst_q <= 1'b0;
            wb_ack  <= 1'b0;
            wb_err  <= 1'b0;
            wb_dato <= '0;
            ack_cnt <= 16'd0;
            err_cnt <= 16'd0;
        end else begin
            wb_ack <= serve & ~oor;
            wb_err <= serve & oor;

            if (serve && !oor && !wb_we) begin
                wb_dato <= mem[idx];
            end else begin
                wb_dato <= '0;
            end

            if (serve && !oor && ack_cnt != 16'hFFFF) begin
                ack_cnt <= ack_cnt + 16'd1;
            end
            if (serve && oor && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        if (WC == 3'd0) begin
                            state   <= S_RESP;
                            burst_q <= cont;
                        end else begin
                            state <= S_WAIT;
                            wcnt  <= WC;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc) begin
                        state <= S_IDLE;
                        wcnt  <= 3'd0;
                    end else if (wcnt <= 3'd1) begin
                        state   <= S_RESP;
                        wcnt    <= 3'd0;
                        burst_q <= cont;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (serve) begin
                        burst_q <= cont;
                    end else begin
                        state   <= S_IDLE;
                        burst_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    wcnt    <= 3'd0;
                    burst_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_resp_mem.sv
// Directed bench for wb_resp_mem: classic vector table, bursts,
// aborts, mid-wait reset and ack counter saturation.
module tb_wb_resp_mem;

    logic        wb_clk = 1'b0;
    logic        wb_resetn;
    logic        wb_cyc, wb_stb, wb_we;
    logic [25:0] wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dati;
    logic [2:0]  wb_cti;
    logic        wb_ack, wb_err;
    logic [31:0] wb_dato;
    logic [15:0] ack_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_acks = 0;
    int exp_errs = 0;

    always #5 wb_clk = ~wb_clk;

    wb_resp_mem #(
        .APP_AW(26), .dw(32), .MEM_AW(8), .WAIT_CYC(2)
    ) dut (
        .wb_clk(wb_clk), .wb_resetn(wb_resetn),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_sel(wb_sel), .wb_dati(wb_dati),
        .wb_cti(wb_cti), .wb_ack(wb_ack), .wb_err(wb_err),
        .wb_dato(wb_dato), .ack_cnt(ack_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [3:0]  sel;
        logic [31:0] dati;
        logic        ack;
        logic [31:0] dato;
    } vec_t;

    vec_t vt [16];

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic count_beat(input logic is_ack);
        if (is_ack) begin
            if (exp_acks < 16'hFFFF) exp_acks++;
        end else begin
            if (exp_errs < 16'hFFFF) exp_errs++;
        end
    endtask

    task automatic idle_bus();
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        wb_we   = 1'b0;
        wb_cti  = 3'b000;
    endtask

    task automatic classic(input vec_t v, input string nm);
        int lat;
        lat = 0;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = v.we;
        wb_addr = v.addr;
        wb_sel  = v.sel;
        wb_dati = v.dati;
        wb_cti  = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wb_ack || wb_err) begin
                lat = k;
                break;
            end
        end
        check({nm, " latency"}, lat, 3);
        check({nm, " ack"}, {31'd0, wb_ack}, {31'd0, v.ack});
        check({nm, " err"}, {31'd0, wb_err}, {31'd0, !v.ack});
        if (!v.we) check({nm, " dato"}, wb_dato, v.dato);
        count_beat(v.ack);
        idle_bus();
        tick();
        check({nm, " release"}, {30'd0, wb_ack, wb_err}, 32'd0);
        check({nm, " ack_cnt"}, {16'd0, ack_cnt}, exp_acks);
        check({nm, " err_cnt"}, {16'd0, err_cnt}, exp_errs);
    endtask

    task automatic burst(input int n, input logic [25:0] a [4],
                         input logic ea [4], input logic [31:0] ed [4],
                         input string nm);
        int lat;
        lat = 0;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = 1'b0;
        wb_sel  = 4'hF;
        wb_addr = a[0];
        wb_cti  = (n == 1) ? 3'b111 : 3'b010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wb_ack || wb_err) begin
                lat = k;
                break;
            end
        end
        check({nm, " first latency"}, lat, 3);
        for (int b = 0; b < n; b++) begin
            if (b > 0) tick();
            check($sformatf("%s beat%0d ack", nm, b),
                  {31'd0, wb_ack}, {31'd0, ea[b]});
            check($sformatf("%s beat%0d err", nm, b),
                  {31'd0, wb_err}, {31'd0, !ea[b]});
            check($sformatf("%s beat%0d dato", nm, b),
                  wb_dato, ea[b] ? ed[b] : 32'd0);
            count_beat(ea[b]);
            if (b + 1 < n) begin
                wb_addr = a[b+1];
                wb_cti  = (b + 2 == n) ? 3'b111 : 3'b010;
            end else begin
                idle_bus();
            end
        end
        tick();
        check({nm, " end quiet"}, {30'd0, wb_ack, wb_err}, 32'd0);
        check({nm, " ack_cnt"}, {16'd0, ack_cnt}, exp_acks);
        check({nm, " err_cnt"}, {16'd0, err_cnt}, exp_errs);
    endtask

    initial begin
        logic [25:0] ba [4];
        logic        be [4];
        logic [31:0] bd [4];
        vec_t        rd;

        vt[0]  = '{1'b1, 26'h010, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
        vt[1]  = '{1'b0, 26'h010, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 26'h010, 4'h2, 32'h0000AA00, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 26'h010, 4'hF, 32'h0,        1'b1, 32'hDEADAAEF};
        vt[4]  = '{1'b0, 26'h013, 4'hF, 32'h0,        1'b1, 32'hDEADAAEF};
        vt[5]  = '{1'b1, 26'h3FC, 4'hF, 32'h12345678, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 26'h3FC, 4'hF, 32'h0,        1'b1, 32'h12345678};
        vt[7]  = '{1'b1, 26'h000, 4'hF, 32'hA5A5A5A5, 1'b1, 32'h0};
        vt[8]  = '{1'b1, 26'h004, 4'hF, 32'h00000004, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 26'h008, 4'hF, 32'h00000008, 1'b1, 32'h0};
        vt[10] = '{1'b1, 26'h00C, 4'hF, 32'h0000000C, 1'b1, 32'h0};
        vt[11] = '{1'b0, 26'h400, 4'hF, 32'h0,        1'b0, 32'h0};
        vt[12] = '{1'b1, 26'h400, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[13] = '{1'b0, 26'h000, 4'hF, 32'h0,        1'b1, 32'hA5A5A5A5};
        vt[14] = '{1'b1, 26'h020, 4'hF, 32'h11111111, 1'b1, 32'h0};
        vt[15] = '{1'b0, 26'h2000000, 4'hF, 32'h0,    1'b0, 32'h0};

        wb_resetn = 1'b0;
        wb_addr   = '0;
        wb_sel    = '0;
        wb_dati   = '0;
        idle_bus();
        tick();
        tick();
        check("reset ack", {31'd0, wb_ack}, 32'd0);
        check("reset err", {31'd0, wb_err}, 32'd0);
        check("reset dato", wb_dato, 32'd0);
        check("reset ack_cnt", {16'd0, ack_cnt}, 32'd0);
        check("reset err_cnt", {16'd0, err_cnt}, 32'd0);
        wb_resetn = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            classic(vt[i], $sformatf("vec%0d", i));
        end

        ba = '{26'h000, 26'h004, 26'h008, 26'h00C};
        be = '{1'b1, 1'b1, 1'b1, 1'b1};
        bd = '{32'hA5A5A5A5, 32'h4, 32'h8, 32'hC};
        burst(4, ba, be, bd, "burst4");

        ba = '{26'h000, 26'h400, 26'h008, 26'h000};
        be = '{1'b1, 1'b0, 1'b1, 1'b1};
        bd = '{32'hA5A5A5A5, 32'h0, 32'h8, 32'h0};
        burst(3, ba, be, bd, "burst_oor");

        // abort during WAIT of a write
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 26'h020; wb_sel = 4'hF; wb_dati = 32'h22222222;
        wb_cti = 3'b000;
        tick();
        tick();
        idle_bus();
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort quiet%0d", k),
                  {30'd0, wb_ack, wb_err}, 32'd0);
        end
        rd = '{1'b0, 26'h020, 4'hF, 32'h0, 1'b1, 32'h11111111};
        classic(rd, "abort readback");

        // reset pulse mid-WAIT
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 26'h020; wb_sel = 4'hF; wb_dati = 32'h33333333;
        tick();
        wb_resetn = 1'b0;
        #1;
        exp_acks = 0;
        exp_errs = 0;
        check("rst mid ack", {31'd0, wb_ack}, 32'd0);
        check("rst mid dato", wb_dato, 32'd0);
        check("rst mid ack_cnt", {16'd0, ack_cnt}, 32'd0);
        check("rst mid err_cnt", {16'd0, err_cnt}, 32'd0);
        tick();
        idle_bus();
        wb_resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst quiet%0d", k),
                  {30'd0, wb_ack, wb_err}, 32'd0);
        end
        classic(rd, "rst readback");

        // ack counter saturation via one long burst
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_addr = 26'h000; wb_sel = 4'hF; wb_cti = 3'b010;
        for (int k = 0; k < 2 + (32'hFFFE - exp_acks); k++) begin
            tick();
        end
        exp_acks = 16'hFFFE;
        check("sat pre ack_cnt", {16'd0, ack_cnt}, exp_acks);
        tick();
        tick();
        wb_cti = 3'b111;
        tick();
        check("sat last ack", {31'd0, wb_ack}, 32'd1);
        idle_bus();
        tick();
        check("sat end quiet", {31'd0, wb_ack}, 32'd0);
        check("sat ack_cnt", {16'd0, ack_cnt}, 32'h0000FFFF);
        check("sat err_cnt", {16'd0, err_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
